// File: rtl/bw_io_term_pkg.sv
// Shared types and helpers for the CMOS2 pull-down termination calibrator.
// FSM state encoding, settle-counter sizing and synchroniser depth.
package bw_io_term_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_e;

  localparam int SYNC_DEPTH = 2;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/bw_io_term_ch_upd.sv
// One termination channel: pending flag plus code register.
// The code only moves while the channel is enabled and its bus is quiet.
module bw_io_term_ch_upd
  import bw_io_term_pkg::*;
#(
  parameter int CODE_W   = 5,
  parameter int RST_CODE = 2 ** (CODE_W - 1)
) (
  input  logic              clk,
  input  logic              arst_l,
  input  logic              i_set,
  input  logic              i_en,
  input  logic              i_quiet,
  input  logic [CODE_W-1:0] i_code,
  output logic [CODE_W-1:0] o_code
);

  logic              r_pend;
  logic [CODE_W-1:0] r_code;

  // A new-result set in the same cycle as an update wins, so the
  // channel picks up the newest code on its next eligible cycle.
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      r_pend <= 1'b0;
      r_code <= CODE_W'(RST_CODE);
    end else begin
      if (r_pend && i_en && i_quiet) begin
        r_code <= i_code;
        r_pend <= 1'b0;
      end
      if (i_set) r_pend <= 1'b1;
    end
  end

  assign o_code = r_code;

endmodule

// File: rtl/bw_io_cmos2_term_cal.sv
// SAR pull-down termination calibrator feeding NCH quiet-gated channels.
// Optional override path enabled by defining BW_IO_TERM_OVRD_EN.
module bw_io_cmos2_term_cal
  import bw_io_term_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int CODE_W     = 5,
  parameter int SETTLE_CYC = 8,
  parameter int RST_CODE   = 2 ** (CODE_W - 1)
) (
  input  logic                  clk,
  input  logic                  arst_l,
  input  logic                  vddo,
  input  logic                  cal_req,
  output logic                  cal_busy,
  output logic                  cal_done,
  input  logic                  cmp_hi,
  output logic [CODE_W-1:0]     trial_code,
  output logic [CODE_W-1:0]     cal_code,
  input  logic [NCH-1:0]        ch_en,
  input  logic [NCH-1:0]        ch_quiet,
`ifdef BW_IO_TERM_OVRD_EN
  input  logic                  ovrd_en,
  input  logic [CODE_W-1:0]     ovrd_code,
`endif
  output logic [NCH*CODE_W-1:0] term_dn_code,
  output logic [NCH-1:0]        term_dn_en
);

  localparam int CW = clog2(SETTLE_CYC + 3);
  localparam int IW = clog2(CODE_W);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC + 1);
  localparam logic [CODE_W-1:0] ONE = CODE_W'(1);

  state_e                r_state;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [CODE_W-1:0]     r_trial;
  logic [CODE_W-1:0]     r_cal;
  logic                  r_busy;
  logic                  r_done;
  logic [NCH-1:0]        r_en;
  logic [SYNC_DEPTH-1:0] r_sync;

  logic              w_cmp_s;
  logic [CODE_W-1:0] w_bit;
  logic [CODE_W-1:0] w_res;
  logic              w_last;
  logic              w_set;
  logic              w_ovrd;
  logic              w_rise;
  logic [CODE_W-1:0] w_ch_code;
  logic              w_unused;

  assign w_unused = vddo;

`ifdef BW_IO_TERM_OVRD_EN
  logic r_ovrd_q;

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) r_ovrd_q <= 1'b0;
    else         r_ovrd_q <= ovrd_en;
  end

  assign w_ovrd    = ovrd_en;
  assign w_rise    = ovrd_en & ~r_ovrd_q;
  assign w_ch_code = ovrd_en ? ovrd_code : r_cal;
`else
  assign w_ovrd    = 1'b0;
  assign w_rise    = 1'b0;
  assign w_ch_code = r_cal;
`endif

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      r_sync <= '0;
      r_en   <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_DEPTH-2:0], cmp_hi};
      r_en   <= ch_en;
    end
  end

  assign w_cmp_s = r_sync[SYNC_DEPTH-1];
  assign w_bit   = ONE << r_idx;
  assign w_res   = w_cmp_s ? r_trial : (r_trial & ~w_bit);
  assign w_last  = (r_state == SAMPLE) && (r_idx == '0);
  // Channels are flagged on the edge the new result lands in cal_code.
  assign w_set   = w_last | w_rise;

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_trial <= CODE_W'(RST_CODE);
      r_cal   <= CODE_W'(RST_CODE);
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (cal_req && !w_ovrd) begin
            r_trial <= ONE << (CODE_W - 1);
            r_idx   <= IW'(CODE_W - 1);
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SETTLE;
          end
        end
        SETTLE: begin
          if (r_cnt == SETTLE_LAST) r_state <= SAMPLE;
          else                      r_cnt   <= r_cnt + 1'b1;
        end
        SAMPLE: begin
          if (r_idx != '0) begin
            r_trial <= w_res | (w_bit >> 1);
            r_idx   <= r_idx - 1'b1;
            r_cnt   <= '0;
            r_state <= SETTLE;
          end else begin
            r_trial <= w_res;
            r_cal   <= w_res;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    bw_io_term_ch_upd #(
      .CODE_W  (CODE_W),
      .RST_CODE(RST_CODE)
    ) u_ch (
      .clk    (clk),
      .arst_l (arst_l),
      .i_set  (w_set),
      .i_en   (ch_en[g]),
      .i_quiet(ch_quiet[g]),
      .i_code (w_ch_code),
      .o_code (term_dn_code[g*CODE_W +: CODE_W])
    );
  end

  assign cal_busy   = r_busy;
  assign cal_done   = r_done;
  assign trial_code = r_trial;
  assign cal_code   = r_cal;
  assign term_dn_en = r_en;

endmodule

// File: tb/tb_bw_io_cmos2_term_cal.sv
// Self-checking bench for bw_io_cmos2_term_cal (default build).
// Comparator threshold model: cmp_hi=1 while trial_code < thr.
module tb_bw_io_cmos2_term_cal;

  localparam int NCH = 4;
  localparam int CW  = 5;
  localparam int LAT = 1 + CW * (8 + 3);

  logic            clk = 1'b0;
  logic            arst_l = 1'b0;
  logic            vddo = 1'b1;
  logic            cal_req = 1'b0;
  logic            cal_busy;
  logic            cal_done;
  logic            cmp_hi;
  logic [CW-1:0]   trial_code;
  logic [CW-1:0]   cal_code;
  logic [NCH-1:0]  ch_en = '0;
  logic [NCH-1:0]  ch_quiet = '0;
  logic [NCH*CW-1:0] term_dn_code;
  logic [NCH-1:0]  term_dn_en;
  logic            ovrd_en = 1'b0;
  logic [CW-1:0]   ovrd_code = '0;

  int unsigned thr = 0;
  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign cmp_hi = (32'(trial_code) < thr);

  bw_io_cmos2_term_cal dut (
    .clk         (clk),
    .arst_l      (arst_l),
    .vddo        (vddo),
    .cal_req     (cal_req),
    .cal_busy    (cal_busy),
    .cal_done    (cal_done),
    .cmp_hi      (cmp_hi),
    .trial_code  (trial_code),
    .cal_code    (cal_code),
    .ch_en       (ch_en),
    .ch_quiet    (ch_quiet),
`ifdef BW_IO_TERM_OVRD_EN
    .ovrd_en     (ovrd_en),
    .ovrd_code   (ovrd_code),
`endif
    .term_dn_code(term_dn_code),
    .term_dn_en  (term_dn_en)
  );

  // Largest code the comparator still reports as too weak.
  function automatic int exp_code(input int unsigned t);
    if (t == 0) return 0;
    if (t > 32) return 31;
    return int'(t) - 1;
  endfunction

  // Trial code shown during bit step k, given the final result.
  function automatic int exp_trial(input int res, input int k);
    int sh;
    sh = CW - k;
    return ((res >> sh) << sh) | (1 << (CW - 1 - k));
  endfunction

  function automatic int ch(input int i);
    return int'(term_dn_code[i*CW +: CW]);
  endfunction

  task automatic run_cal(input bit hold, output int n);
    n = -1;
    cal_req = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (!hold) cal_req = 1'b0;
      if (cal_done) begin
        n = k;
        break;
      end
    end
    cal_req = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    checks++;
    if (cal_code !== 5'd16 || trial_code !== 5'd16 || cal_busy !== 1'b0 ||
        cal_done !== 1'b0 || term_dn_en !== '0) begin
      errs++;
      $display("FAIL reset_init: cal=%0d trial=%0d busy=%b done=%b en=%b req 16/16/0/0/0",
               cal_code, trial_code, cal_busy, cal_done, term_dn_en);
    end
    for (int i = 0; i < NCH; i++) begin
      checks++;
      if (ch(i) !== 16) begin
        errs++;
        $display("FAIL reset_ch%0d: got %0d req 16", i, ch(i));
      end
    end
    @(negedge clk);
    arst_l = 1'b1;
    @(negedge clk);
    ch_en = '1;
    ch_quiet = '1;
    thr = 8;
    run_cal(1'b0, n);
    checks++;
    if (n !== LAT || cal_code !== 5'(exp_code(thr))) begin
      errs++;
      $display("FAIL pre_reset_cal: lat=%0d cal=%0d req %0d/%0d", n, cal_code, LAT, exp_code(thr));
    end
    @(negedge clk);
    checks++;
    if (ch(0) !== 7 || ch(3) !== 7 || term_dn_en !== 4'hF) begin
      errs++;
      $display("FAIL pre_reset_ch: ch0=%0d ch3=%0d en=%h req 7/7/f", ch(0), ch(3), term_dn_en);
    end
    cal_req = 1'b1;
    repeat (6) begin
      @(negedge clk);
      cal_req = 1'b0;
    end
    arst_l = 1'b0;
    #1;
    checks++;
    if (cal_code !== 5'd16 || trial_code !== 5'd16 || cal_busy !== 1'b0 ||
        term_dn_en !== '0 || ch(0) !== 16 || ch(3) !== 16) begin
      errs++;
      $display("FAIL reset_mid: cal=%0d trial=%0d busy=%b en=%b ch0=%0d req 16/16/0/0/16",
               cal_code, trial_code, cal_busy, term_dn_en, ch(0));
    end
    ch_en = '0;
    ch_quiet = '0;
    @(negedge clk);
    arst_l = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sar_channels;
    int n;
    bit held;
    thr = 20;
    ch_en = 4'b0111;
    ch_quiet = 4'b1011;
    run_cal(1'b0, n);
    checks++;
    if (n !== LAT || cal_code !== 5'b10011) begin
      errs++;
      $display("FAIL sar19: lat=%0d cal=%0d req %0d/19", n, cal_code, LAT);
    end
    checks++;
    if (ch(0) !== 16) begin
      errs++;
      $display("FAIL ch0_early: got %0d req 16", ch(0));
    end
    @(negedge clk);
    checks++;
    if (ch(0) !== 19 || ch(1) !== 19 || ch(2) !== 16 || ch(3) !== 16 || cal_done !== 1'b0) begin
      errs++;
      $display("FAIL ch_after_done: %0d %0d %0d %0d done=%b req 19 19 16 16 0",
               ch(0), ch(1), ch(2), ch(3), cal_done);
    end
    held = 1'b1;
    repeat (19) begin
      @(negedge clk);
      if (ch(2) !== 16) held = 1'b0;
    end
    checks++;
    if (!held) begin
      errs++;
      $display("FAIL ch2_noisy: got %0d req 16", ch(2));
    end
    ch_quiet[2] = 1'b1;
    @(negedge clk);
    checks++;
    if (ch(2) !== 19 || ch(3) !== 16) begin
      errs++;
      $display("FAIL ch2_quiet: ch2=%0d ch3=%0d req 19/16", ch(2), ch(3));
    end
    ch_en[3] = 1'b1;
    @(negedge clk);
    checks++;
    if (ch(3) !== 19 || term_dn_en !== 4'hF) begin
      errs++;
      $display("FAIL ch3_enable: ch3=%0d en=%h req 19/f", ch(3), term_dn_en);
    end
  endtask

  task automatic test_ignore_req;
    int dones;
    int at;
    thr = $urandom_range(0, 33);
    dones = 0;
    at = -1;
    cal_req = 1'b1;
    for (int k = 1; k <= 130; k++) begin
      @(negedge clk);
      cal_req = (k == 10);
      if (cal_done) begin
        dones++;
        at = k;
      end
    end
    cal_req = 1'b0;
    checks++;
    if (dones !== 1 || at !== LAT || cal_code !== 5'(exp_code(thr))) begin
      errs++;
      $display("FAIL ignore_req: dones=%0d at=%0d cal=%0d req 1/%0d/%0d",
               dones, at, cal_code, LAT, exp_code(thr));
    end
  endtask

  task automatic test_back_to_back;
    int t[$];
    thr = $urandom_range(1, 32);
    cal_req = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (cal_done) t.push_back(k);
    end
    cal_req = 1'b0;
    checks++;
    if (t.size() !== 3) begin
      errs++;
      $display("FAIL b2b_count: got %0d req 3", t.size());
    end else begin
      checks++;
      if (t[0] !== LAT || t[1] - t[0] !== LAT + 1 || t[2] - t[1] !== LAT + 1) begin
        errs++;
        $display("FAIL b2b_period: %0d %0d %0d req %0d +%0d", t[0], t[1], t[2], LAT, LAT + 1);
      end
    end
    for (int k = 0; k < 100 && cal_busy; k++) @(negedge clk);
    checks++;
    if (cal_busy !== 1'b0 || cal_code !== 5'(exp_code(thr))) begin
      errs++;
      $display("FAIL b2b_end: busy=%b cal=%0d req 0/%0d", cal_busy, cal_code, exp_code(thr));
    end
  endtask

  task automatic test_steps(input int unsigned t);
    int n;
    int res;
    int bad;
    thr = t;
    res = exp_code(t);
    bad = 0;
    n = -1;
    cal_req = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      cal_req = 1'b0;
      if ((k - 1) % 11 == 0 && k < LAT) begin
        checks++;
        if (int'(trial_code) !== exp_trial(res, (k - 1) / 11)) begin
          errs++;
          $display("FAIL trial_step thr=%0d k=%0d: got %0d req %0d",
                   t, k, trial_code, exp_trial(res, (k - 1) / 11));
        end
      end
      if (cal_done) begin
        n = k;
        break;
      end
    end
    checks++;
    if (n !== LAT || int'(cal_code) !== res) begin
      errs++;
      $display("FAIL steps_result thr=%0d: lat=%0d cal=%0d req %0d/%0d", t, n, cal_code, LAT, res);
    end
    @(negedge clk);
  endtask

  task automatic test_random_quiet;
    int prev[NCH];
    logic [NCH-1:0] q;
    int res;
    int bad;
    ch_en = '1;
    for (int it = 0; it < 4; it++) begin
      thr = $urandom_range(0, 34);
      res = exp_code(thr);
      bad = 0;
      cal_req = 1'b1;
      for (int k = 1; k <= 90; k++) begin
        for (int i = 0; i < NCH; i++) prev[i] = ch(i);
        q = 4'($urandom);
        ch_quiet = q;
        @(negedge clk);
        cal_req = 1'b0;
        for (int i = 0; i < NCH; i++)
          if (!q[i] && ch(i) !== prev[i]) bad++;
      end
      checks++;
      if (bad !== 0) begin
        errs++;
        $display("FAIL quiet_hold it=%0d: %0d changes while busy bus", it, bad);
      end
      ch_quiet = '1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < NCH; i++) begin
        checks++;
        if (ch(i) !== res) begin
          errs++;
          $display("FAIL rand_ch%0d it=%0d: got %0d req %0d", i, it, ch(i), res);
        end
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset;
    test_sar_channels;
    test_ignore_req;
    test_back_to_back;
    test_steps(32'hFFFF);
    test_steps(0);
    test_steps($urandom_range(1, 31));
    test_random_quiet;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
